// File: rtl/cache_block_memory.sv
// Block-granular main memory behind the data cache: 128-bit reads and write-backs with fixed latency.
// Optional CACHE_MEM_PATTERN_INIT_EN fills the array with {block, word} at time 0.
module cache_block_memory #(
  parameter int BLOCK_ADDR_WIDTH = 28,
  parameter int DEPTH            = 256,
  parameter int LATENCY          = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [BLOCK_ADDR_WIDTH-1:0] mem_address,
  input  logic [127:0]                mem_writedata,
  output logic [127:0]                mem_readdata,
  output logic                        mem_busywait
);
  localparam int         IW   = $clog2(DEPTH);
  localparam logic [7:0] LAST = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic           commit;
  logic           req;
  logic [IW-1:0]  idx;
  logic [127:0]   rdata_q;
  logic [127:0]   mem_q [DEPTH];

  // Upper address bits alias onto the same block.
  logic unused_addr;
  assign unused_addr = ^mem_address[BLOCK_ADDR_WIDTH-1:IW];

  assign req          = mem_read | mem_write;
  assign idx          = mem_address[IW-1:0];
  assign mem_readdata = rdata_q;

`ifdef CACHE_MEM_PATTERN_INIT_EN
  initial begin
    for (int b = 0; b < DEPTH; b++)
      for (int w = 0; w < 4; w++)
        mem_q[b][w*32 +: 32] = {b[29:0], w[1:0]};
  end
`else
  // Array contents stay undefined until written.
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    commit       = 1'b0;
    mem_busywait = 1'b0;
    case (state_q)
      IDLE: begin
        mem_busywait = req;
        if (req) begin
          wr_d    = mem_write;  // write wins when both are asserted
          cnt_d   = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_busywait = 1'b1;
        if (!req) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            commit  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      if (commit && !wr_q) rdata_q <= mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && wr_q) mem_q[idx] <= mem_writedata;
  end
endmodule
